dense_stream: RTL and testbench
===============================

Name: dense_stream

Overview:
- Fully connected (flatten + dense) layer that sits directly downstream of the max-pool stage in the keyword-spotting CNN.
- Accepts the pooled activation vector as a valid/ready stream (20 positions x 8 channels = 160 words), buffers it, and runs one MAC per cycle against weights fetched from an external weight memory.
- Emits NUM_OUT saturated class scores on an output valid/ready stream, then re-arms for the next frame.

Parameters:
- IN_LEN, 160, activations per frame (flattened length)
- NUM_OUT, 12, output neurons / classes
- ACTIV_BITS, 16, signed activation and output width
- WEIGHT_BITS, 8, signed weight width
- BIAS_BITS, 32, signed bias width
- ACC_BITS, 40, signed accumulator width
- OUT_SHIFT, 8, arithmetic right shift applied before saturation

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  activation beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  ACTIV_BITS  signed activation
- in_last  in  1  marks final beat of frame
- w_rd_en  out  1  weight/bias read strobe
- w_addr  out  clog2(IN_LEN*NUM_OUT)  weight address, o*IN_LEN+i
- w_data  in  WEIGHT_BITS  weight; valid exactly 1 cycle after w_rd_en
- b_addr  out  clog2(NUM_OUT)  bias address, equals current neuron o
- b_data  in  BIAS_BITS  bias; valid 1 cycle after b_addr changes, stable thereafter
- out_valid  out  1  score valid
- out_ready  in  1  consumer accepts score
- out_data  out  ACTIV_BITS  signed score
- out_idx  out  clog2(NUM_OUT)  neuron index of out_data
- out_last  out  1  high with out_idx==NUM_OUT-1
- busy  out  1  state != IDLE/LOAD
- err_len  out  1  one-cycle pulse on frame-length mismatch

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, counters 0, accumulator 0. Activation buffer contents are undefined, and no reset is required for the buffer.
- IDLE -> LOAD unconditionally on the next cycle.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, write in_data to buf[cnt] and increment cnt.
  - Exit to MAC after beat IN_LEN-1, or on an early in_last.
  - in_last at cnt<IN_LEN-1: pulse err_len; remaining entries are treated as 0 during MAC.
  - Beat IN_LEN-1 without in_last: pulse err_len; proceed normally.
- MAC, per neuron o:
  - Issue w_rd_en with i=0..IN_LEN-1 on consecutive cycles.
  - One cycle later: acc += sext(buf[i]) * sext(w_data).
  - Takes IN_LEN+1 cycles; acc cleared at neuron start.
  - w_rd_en is low in every other state.
- BIAS (1 cycle):
  - acc += sext(b_data).
  - r = acc >>> OUT_SHIFT (floor).
  - Saturate r to [-2^(ACTIV_BITS-1), 2^(ACTIV_BITS-1)-1].
  - Register the result into out_data.
- EMIT:
  - out_valid=1; out_data, out_idx and out_last are held stable until out_ready.
  - On handshake: if o<NUM_OUT-1, increment o and go to MAC; else go to IDLE.
- Latency per neuron: IN_LEN+2 cycles to out_valid, plus backpressure.
- Reset asserted in any state aborts the frame immediately. No partial output is emitted.
- No wrap or overflow handling is needed inside acc; ACC_BITS is sized for the worst case.

Optional Feature:
- DENSE_RELU_EN
  - Defined: after saturation, negative scores are clamped to 0 (use for hidden dense layers).
  - Undefined: signed scores pass through unchanged (final logit layer).

Decomposition:
- Package dense_pkg holds:
  - state encoding (IDLE, LOAD, MAC, BIAS, EMIT)
  - ACC_BITS default
  - function sat_shift(acc, shift) returning the saturated ACTIV_BITS value
- One sub-module, dense_mac:
  - registered signed multiply-accumulate with clr and en inputs
  - one pipeline stage aligned to the w_data latency

Test Plan:
- Basic (IN_LEN=4, NUM_OUT=2, OUT_SHIFT=0, bias 0):
  - Stimulus: acts {1,2,3,4}; W row0 {1,1,1,1}, row1 {-1,0,0,0}.
  - Response: out (idx0, 10), then (idx1, -1, out_last=1); with DENSE_RELU_EN, idx1 score is 0.
- Saturation:
  - Stimulus: acts all 32767, weights all 127. Response: 0x7FFF.
  - Stimulus: weights all -128. Response: 0x8000.
- Bias/shift (OUT_SHIFT=3):
  - Dot product 1000 plus bias 24 -> 128.
  - Dot product -9 plus bias 0 -> -2 (floor).
- Backpressure: out_ready held low 10 cycles with out_valid high -> out_data/out_idx stable, w_rd_en low, no advance; handshake then proceeds to the next neuron.
- Length error:
  - Stimulus: in_last on beat 2 of 4, acts {5,5,5}, weights all 1.
  - Response: err_len single pulse; score 15 (buf[3] treated as 0).
- Reset mid-MAC: assert rst during neuron 0 MAC -> all outputs 0 immediately; after release, IDLE then LOAD with in_ready=1; the next frame produces correct scores.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense (fully connected) layer: FSM encoding,
// default accumulator/activation widths and the shift-then-saturate function.
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_MAC  = 3'd2,
        ST_BIAS = 3'd3,
        ST_EMIT = 3'd4
    } state_t;

    localparam int DENSE_ACC_BITS   = 40;
    localparam int DENSE_ACTIV_BITS = 16;

    localparam logic signed [DENSE_ACC_BITS-1:0] SAT_HI =
        {{(DENSE_ACC_BITS-DENSE_ACTIV_BITS+1){1'b0}}, {(DENSE_ACTIV_BITS-1){1'b1}}};
    localparam logic signed [DENSE_ACC_BITS-1:0] SAT_LO = ~SAT_HI;

    // Arithmetic (floor) shift followed by clamping into the signed activation range.
    function automatic logic signed [DENSE_ACTIV_BITS-1:0] sat_shift(
        input logic signed [DENSE_ACC_BITS-1:0] acc,
        input int                               shift
    );
        logic signed [DENSE_ACC_BITS-1:0] r;
        r = acc >>> shift;
        if (r > SAT_HI) begin
            return SAT_HI[DENSE_ACTIV_BITS-1:0];
        end
        if (r < SAT_LO) begin
            return SAT_LO[DENSE_ACTIV_BITS-1:0];
        end
        return r[DENSE_ACTIV_BITS-1:0];
    endfunction

endpackage

// File: rtl/dense_mac.sv
// Registered signed multiply-accumulate. The activation operand and enable are delayed
// one cycle so they meet the weight that returns one cycle after the read strobe.
module dense_mac
    import dense_pkg::*;
#(
    parameter int A_BITS   = DENSE_ACTIV_BITS,
    parameter int W_BITS   = 8,
    parameter int B_BITS   = 32,
    parameter int ACC_BITS = DENSE_ACC_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [A_BITS-1:0]   act,
    input  logic signed [W_BITS-1:0]   w,
    input  logic                       bias_en,
    input  logic signed [B_BITS-1:0]   bias,
    output logic signed [ACC_BITS-1:0] acc_biased
);

    logic                             en_d;
    logic signed [A_BITS-1:0]         act_d;
    logic signed [A_BITS+W_BITS-1:0]  prod;
    logic signed [ACC_BITS-1:0]       acc;

    assign prod       = act_d * w;
    assign acc_biased = acc + ACC_BITS'(bias);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d  <= 1'b0;
            act_d <= '0;
            acc   <= '0;
        end else begin
            en_d  <= en;
            act_d <= act;
            if (clr) begin
                acc <= '0;
            end else if (en_d) begin
                acc <= acc + ACC_BITS'(prod);
            end else if (bias_en) begin
                acc <= acc_biased;
            end
        end
    end

endmodule

// File: rtl/dense_stream.sv
// Flatten + dense layer: buffers one activation frame, then streams NUM_OUT saturated scores.
// Build option DENSE_RELU_EN clamps negative scores to zero (hidden-layer use).
module dense_stream
    import dense_pkg::*;
#(
    parameter int IN_LEN      = 160,
    parameter int NUM_OUT     = 12,
    parameter int ACTIV_BITS  = DENSE_ACTIV_BITS,
    parameter int WEIGHT_BITS = 8,
    parameter int BIAS_BITS   = 32,
    parameter int ACC_BITS    = DENSE_ACC_BITS,
    parameter int OUT_SHIFT   = 8,
    localparam int WA_BITS    = $clog2(IN_LEN * NUM_OUT),
    localparam int IDX_BITS   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [ACTIV_BITS-1:0]  in_data,
    input  logic                          in_last,
    output logic                          w_rd_en,
    output logic [WA_BITS-1:0]            w_addr,
    input  logic signed [WEIGHT_BITS-1:0] w_data,
    output logic [IDX_BITS-1:0]           b_addr,
    input  logic signed [BIAS_BITS-1:0]   b_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACTIV_BITS-1:0]  out_data,
    output logic [IDX_BITS-1:0]           out_idx,
    output logic                          out_last,
    output logic                          busy,
    output logic                          err_len,
    output logic [2:0]                    state_dbg
);

    localparam int CNT_BITS = $clog2(IN_LEN + 1);
    localparam int IB       = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;

    state_t state, state_nx;

    logic [CNT_BITS-1:0]          cnt;
    logic [CNT_BITS-1:0]          i_q;
    logic [IDX_BITS-1:0]          o_q;
    logic signed [ACTIV_BITS-1:0] act_buf [IN_LEN];
    logic signed [ACTIV_BITS-1:0] act_rd;
    logic signed [ACTIV_BITS-1:0] score;
    logic signed [ACC_BITS-1:0]   acc_biased;
    logic [WA_BITS-1:0]           w_lin;
    logic                         in_fire, out_fire, issue, last_beat, o_last, mac_done;

    // Handshakes: a beat/score transfers on a rising clk edge where valid && ready are both
    // high; a producer holding valid keeps its payload stable until that edge.
    assign in_fire   = (state == ST_LOAD) && in_valid;
    assign out_fire  = (state == ST_EMIT) && out_ready;
    assign issue     = (state == ST_MAC) && (i_q < CNT_BITS'(IN_LEN));
    assign mac_done  = (i_q == CNT_BITS'(IN_LEN));
    assign last_beat = in_last || (cnt == CNT_BITS'(IN_LEN - 1));
    assign o_last    = (o_q == IDX_BITS'(NUM_OUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: state_nx = ST_LOAD;
            ST_LOAD: if (in_fire && last_beat) state_nx = ST_MAC;
            ST_MAC:  if (mac_done) state_nx = ST_BIAS;
            ST_BIAS: state_nx = ST_EMIT;
            ST_EMIT: if (out_fire) state_nx = o_last ? ST_IDLE : ST_MAC;
            default: state_nx = ST_IDLE;
        endcase
    end

    // cnt keeps the number of beats actually received so short frames read back as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            i_q      <= '0;
            o_q      <= '0;
            err_len  <= 1'b0;
            out_data <= '0;
        end else begin
            err_len <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    i_q <= '0;
                    o_q <= '0;
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        cnt     <= cnt + 1'b1;
                        err_len <= in_last ^ (cnt == CNT_BITS'(IN_LEN - 1));
                    end
                end
                ST_MAC: begin
                    i_q <= mac_done ? '0 : i_q + 1'b1;
                end
                ST_BIAS: begin
                    out_data <= score;
                end
                ST_EMIT: begin
                    if (out_fire && !o_last) begin
                        o_q <= o_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            act_buf[cnt[IB-1:0]] <= in_data;
        end
    end

    assign act_rd = (i_q < cnt) ? act_buf[i_q[IB-1:0]] : '0;

    dense_mac #(
        .A_BITS   (ACTIV_BITS),
        .W_BITS   (WEIGHT_BITS),
        .B_BITS   (BIAS_BITS),
        .ACC_BITS (ACC_BITS)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr        (issue && (i_q == '0)),
        .en         (issue),
        .act        (act_rd),
        .w          (w_data),
        .bias_en    (state == ST_BIAS),
        .bias       (b_data),
        .acc_biased (acc_biased)
    );

    always_comb begin
        score = ACTIV_BITS'(sat_shift(DENSE_ACC_BITS'(acc_biased), OUT_SHIFT));
`ifdef DENSE_RELU_EN
        if (score[ACTIV_BITS-1]) begin
            score = '0;
        end
`endif
    end

    assign w_lin     = WA_BITS'(o_q) * WA_BITS'(IN_LEN) + WA_BITS'(i_q);
    assign w_addr    = issue ? w_lin : '0;
    assign w_rd_en   = issue;
    assign b_addr    = o_q;
    assign in_ready  = (state == ST_LOAD);
    assign out_valid = (state == ST_EMIT);
    assign out_idx   = o_q;
    assign out_last  = (state == ST_EMIT) && o_last;
    assign busy      = (state != ST_IDLE) && (state != ST_LOAD);
    assign state_dbg = state;

endmodule

// File: tb/tb_dense_stream.sv
// Bench for dense_stream: two instances (OUT_SHIFT 0 and 3) run in lockstep on the same
// frames; scores are checked against a plain-arithmetic reference model.
module tb_dense_stream;
    import dense_pkg::*;

    localparam int IN_LEN  = 4;
    localparam int NUM_OUT = 2;
    localparam int AB      = 16;
    localparam int WB      = 8;
    localparam int BB      = 32;
    localparam int WA      = 3;
    localparam int IX      = 1;
    localparam int LAT     = IN_LEN + 2;
    localparam int BOUND   = 200;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic signed [AB-1:0] in_data;

    logic in_ready0, in_ready3, w_rd_en0, w_rd_en3;
    logic [WA-1:0] w_addr0, w_addr3;
    logic signed [WB-1:0] w_data0, w_data3;
    logic [IX-1:0] b_addr0, b_addr3;
    logic signed [BB-1:0] b_data0, b_data3;
    logic out_valid0, out_valid3, out_last0, out_last3;
    logic signed [AB-1:0] out_data0, out_data3;
    logic [IX-1:0] out_idx0, out_idx3;
    logic busy0, busy3, err_len0, err_len3;
    logic [2:0] st0, st3;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int err_cnt = 0;

    int acts [IN_LEN];
    int wts  [NUM_OUT][IN_LEN];
    int bias [NUM_OUT];
    logic signed [WB-1:0] wmem [IN_LEN*NUM_OUT];
    logic signed [BB-1:0] bmem [NUM_OUT];
    logic [33:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    dense_stream #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .OUT_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_last(in_last), .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data0),
        .b_addr(b_addr0), .b_data(b_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_idx(out_idx0), .out_last(out_last0), .busy(busy0),
        .err_len(err_len0), .state_dbg(st0)
    );

    dense_stream #(.IN_LEN(IN_LEN), .NUM_OUT(NUM_OUT), .OUT_SHIFT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .in_last(in_last), .w_rd_en(w_rd_en3), .w_addr(w_addr3), .w_data(w_data3),
        .b_addr(b_addr3), .b_data(b_data3), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .out_idx(out_idx3), .out_last(out_last3), .busy(busy3),
        .err_len(err_len3), .state_dbg(st3)
    );

    // Weight memory: data one cycle after the strobe, noise otherwise. Bias follows b_addr.
    always @(posedge clk) begin
        w_data0 <= w_rd_en0 ? wmem[w_addr0] : WB'($urandom);
        w_data3 <= w_rd_en3 ? wmem[w_addr3] : WB'($urandom);
        b_data0 <= bmem[b_addr0];
        b_data3 <= bmem[b_addr3];
        if (w_rd_en0) rd_cnt <= rd_cnt + 1;
        if (err_len0) err_cnt <= err_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [AB-1:0] model_score(input int o, input int shift, input int len);
        longint s, d, q;
        s = longint'(bias[o]);
        for (int i = 0; i < IN_LEN; i++) begin
            if (i < len) s += longint'(acts[i]) * longint'(wts[o][i]);
        end
        d = longint'(1) << shift;
        q = s / d;
        if ((s % d) != 0 && s < 0) q -= 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef DENSE_RELU_EN
        if (q < 0) q = 0;
`endif
        return AB'(q);
    endfunction

    task automatic prep_expect(input int len);
        for (int o = 0; o < NUM_OUT; o++) begin
            exp_q.push_back({(o == NUM_OUT-1), IX'(o), model_score(o, 0, len), model_score(o, 3, len)});
        end
    endtask

    // ---------------- drivers ----------------
    task automatic load_mems();
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < IN_LEN; i++) wmem[o*IN_LEN+i] = WB'(wts[o][i]);
            bmem[o] = BB'(bias[o]);
        end
    endtask

    task automatic randomize_frame(input int amp);
        for (int i = 0; i < IN_LEN; i++) acts[i] = int'($urandom_range(0, 2*amp)) - amp;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < IN_LEN; i++) wts[o][i] = int'($urandom_range(0, 255)) - 128;
            bias[o] = int'($urandom_range(0, 8192)) - 4096;
        end
    endtask

    task automatic send_frame(input int nbeats, input int last_at);
        int n;
        logic exp_err;
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_data  = AB'(acts[k]);
            in_last  = (k == last_at);
            n = 0;
            while (!in_ready0 && n < BOUND) begin
                @(posedge clk); #1;
                n++;
            end
            check("in_ready", in_ready0, 1);
            @(posedge clk); #1;
            exp_err = ((k == last_at) && (k < IN_LEN-1)) || ((k == IN_LEN-1) && (k != last_at));
            check("err_len0", err_len0, exp_err);
            check("err_len3", err_len3, exp_err);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic take_out(input int hold, input bit bp);
        logic [33:0] e;
        logic signed [AB-1:0] ex0, ex3;
        e = '0;
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        ex0 = e[31:16];
        ex3 = e[15:0];
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(posedge clk); #1;
            end
            check("out_valid0", out_valid0, 1);
            check("out_valid3", out_valid3, 1);
            check("busy", busy0 & busy3, 1);
            check("out_data0", out_data0, ex0);
            check("out_data3", out_data3, ex3);
            check("out_idx", {out_idx3, out_idx0}, {e[32], e[32]});
            check("out_last", {out_last3, out_last0}, {e[33], e[33]});
            if (bp) check("bp_no_read", w_rd_en0 | w_rd_en3, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic collect(input bit bp);
        int n, hold;
        for (int o = 0; o < NUM_OUT; o++) begin
            n = 0;
            while (!out_valid0 && n < BOUND) begin
                @(posedge clk); #1;
                n++;
            end
            check("latency", n, LAT);
            hold = (bp && o == 0) ? 10 : int'($urandom_range(0, 3));
            take_out(hold, bp && o == 0);
        end
    endtask

    task automatic run_frame(input int nbeats, input int last_at, input bit bp);
        int rd0, er0, exp_pulses;
        load_mems();
        prep_expect(nbeats);
        rd0 = rd_cnt;
        er0 = err_cnt;
        exp_pulses = (nbeats != IN_LEN || last_at != IN_LEN-1) ? 1 : 0;
        send_frame(nbeats, last_at);
        collect(bp);
        check("w_reads", rd_cnt - rd0, IN_LEN*NUM_OUT);
        check("err_pulses", err_cnt - er0, exp_pulses);
        check("exp_q_drained", exp_q.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        acts = '{0, 0, 0, 0};
        wts  = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        bias = '{0, 0};
        load_mems();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {in_ready3, in_ready0}, 0);
        check("rst_out_valid", {out_valid3, out_valid0}, 0);
        check("rst_w_rd_en", {w_rd_en3, w_rd_en0}, 0);
        check("rst_busy_err", {busy3, busy0, err_len3, err_len0}, 0);
        check("rst_out_data", {out_data3, out_data0}, 0);
        check("rst_state", st0, ST_IDLE);
        check("rst_state3", st3, ST_IDLE);
        rst = 1'b0;
        @(posedge clk); #1;
        check("load_after_idle", in_ready0, 1);

        // basic, with 10 cycles of backpressure on the first score
        acts = '{1, 2, 3, 4};
        wts  = '{'{1, 1, 1, 1}, '{-1, 0, 0, 0}};
        bias = '{0, 0};
        run_frame(4, 3, 1'b1);

        // early in_last: only three beats, stale buf[3] must read as zero
        acts = '{5, 5, 5, 4};
        wts  = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}};
        run_frame(3, 2, 1'b0);

        // saturation both directions
        acts = '{32767, 32767, 32767, 32767};
        wts  = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128}};
        run_frame(4, 3, 1'b0);

        // bias and floor shift: 1000+24 and -9+0
        acts = '{1000, -9, 0, 0};
        wts  = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}};
        bias = '{24, 0};
        run_frame(4, 3, 1'b0);

        // final beat without in_last
        randomize_frame(50);
        run_frame(4, -1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            randomize_frame((f % 3 == 0) ? 50 : ((f % 3 == 1) ? 1000 : 32767));
            run_frame(4, 3, 1'b0);
        end

        // reset during neuron 0 MAC
        randomize_frame(1000);
        load_mems();
        send_frame(4, 3);
        repeat (2) @(posedge clk);
        #1;
        check("mid_mac_reading", w_rd_en0, 1);
        rst = 1'b1;
        #1;
        check("abort_w_rd_en", {w_rd_en3, w_rd_en0}, 0);
        check("abort_w_addr", {w_addr3, w_addr0}, 0);
        check("abort_b_addr", {b_addr3, b_addr0}, 0);
        check("abort_out", {out_valid3, out_valid0, out_last3, out_last0, out_idx3, out_idx0}, 0);
        check("abort_out_data", {out_data3, out_data0}, 0);
        check("abort_busy", {busy3, busy0, in_ready3, in_ready0, err_len3, err_len0}, 0);
        #2;
        rst = 1'b0;
        check("post_rst_idle", st0, ST_IDLE);
        @(posedge clk); #1;
        check("post_rst_load", st0, ST_LOAD);
        check("post_rst_in_ready", in_ready0, 1);
        randomize_frame(50);
        run_frame(4, 3, 1'b0);
        randomize_frame(1000);
        run_frame(4, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
